// File: rtl/bus_pkg.sv
// Shared address map, register widths and seven-segment codes for the peripheral responder.
package bus_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DIG    = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TIMER  = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_LED    = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW     = 32'hFFFF_F070;

  localparam int LED_W = 24;
  localparam int SW_W  = 24;

  // Active-low codes ordered {dp,g,f,e,d,c,b,a}; dp is always dark.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  function automatic logic [9:0] word_off(input logic [31:0] addr);
    return addr[11:2];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment code; purely combinational, no backpressure.
module seg7_decode
  import bus_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/bus_periph_resp.sv
// Peripheral window responder (DIG, TIMER, LED, SW); reads combinational, writes take effect at the edge.
// Optional timer counter built only when BUS_TIMER_EN is defined; the bus never stalls.
module bus_periph_resp
  import bus_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Bus_addr,
  input  logic             Bus_we,
  input  logic [31:0]      Bus_wdata,
  output logic [31:0]      Bus_rdata,
  output logic             periph_hit,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic [7:0]       dig_en,
  output logic [7:0]       seg
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      dig_q, dig_d;
  logic [SW_W-1:0]  sw1_q, sw1_d, sw_sync_q, sw_sync_d;
  logic [CW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [2:0]       dig_idx_q, dig_idx_d;
  logic [31:0]      timer_rd;
  logic [9:0]       off;
  logic             sel_dig, sel_timer, sel_led, sel_sw, wr;
  logic [7:0]       seg_raw;

  wire unused_addr = ^Bus_addr[1:0];

  assign periph_hit = (Bus_addr[31:12] == PERIPH_BASE[31:12]);
  assign off        = word_off(Bus_addr);
  assign sel_dig    = periph_hit && (off == word_off(ADDR_DIG));
  assign sel_timer  = periph_hit && (off == word_off(ADDR_TIMER));
  assign sel_led    = periph_hit && (off == word_off(ADDR_LED));
  assign sel_sw     = periph_hit && (off == word_off(ADDR_SW));
  assign wr         = Bus_we && periph_hit;

  always_comb begin
    led_d      = led_q;
    dig_d      = dig_q;
    sw1_d      = sw;
    sw_sync_d  = sw1_q;
    scan_cnt_d = scan_cnt_q + CW'(1);
    dig_idx_d  = dig_idx_q;
    if (wr && sel_led) led_d = Bus_wdata[LED_W-1:0];
    if (wr && sel_dig) dig_d = Bus_wdata;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q      <= '0;
      dig_q      <= '0;
      sw1_q      <= '0;
      sw_sync_q  <= '0;
      scan_cnt_q <= '0;
      dig_idx_q  <= '0;
    end else begin
      led_q      <= led_d;
      dig_q      <= dig_d;
      sw1_q      <= sw1_d;
      sw_sync_q  <= sw_sync_d;
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
    end
  end

`ifdef BUS_TIMER_EN
  logic [31:0] timer_q, timer_d;

  // A load replaces the increment for that cycle.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (wr && sel_timer) timer_d = Bus_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  always_comb begin
    Bus_rdata = '0;
    if (sel_dig)   Bus_rdata = dig_q;
    if (sel_timer) Bus_rdata = timer_rd;
    if (sel_led)   Bus_rdata = {{(32-LED_W){1'b0}}, led_q};
    if (sel_sw)    Bus_rdata = {{(32-SW_W){1'b0}}, sw_sync_q};
  end

  seg7_decode u_dec (
    .nib (dig_q[{dig_idx_q, 2'b00} +: 4]),
    .seg (seg_raw)
  );

  assign led    = led_q;
  assign dig_en = ~(8'b1 << dig_idx_q);
  assign seg    = seg_raw | 8'h80;

endmodule

// File: tb/tb_bus_periph_resp.sv
// Directed bench for bus_periph_resp: vector table for bus decode plus hand sequences for scan, sync and timer.
module tb_bus_periph_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Bus_addr;
  logic        Bus_we;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;
  logic        periph_hit;
  logic [23:0] sw;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bus_periph_resp #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Bus_addr   (Bus_addr),
    .Bus_we     (Bus_we),
    .Bus_wdata  (Bus_wdata),
    .Bus_rdata  (Bus_rdata),
    .periph_hit (periph_hit),
    .sw         (sw),
    .led        (led),
    .dig_en     (dig_en),
    .seg        (seg)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic [23:0] exp_led;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  logic [7:0] seg_tab [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  prev;
    logic [31:0] tval;
    bit          found;

    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 24'h0};
    vecs[1]  = '{1'b1, 32'hFFFF_F060, 32'hAB12_3456, 32'h0,         1'b1, 24'h123456};
    vecs[2]  = '{1'b0, 32'hFFFF_F060, 32'h0,         32'h0012_3456, 1'b1, 24'h123456};
    vecs[3]  = '{1'b1, 32'h0000_0060, 32'h5,         32'h0,         1'b0, 24'h123456};
    vecs[4]  = '{1'b0, 32'hFFFF_F063, 32'h0,         32'h0012_3456, 1'b1, 24'h123456};
    vecs[5]  = '{1'b0, 32'hFFFF_F040, 32'h0,         32'h0,         1'b1, 24'h123456};
    vecs[6]  = '{1'b1, 32'hFFFF_F040, 32'hDEAD_BEEF, 32'h0,         1'b1, 24'h123456};
    vecs[7]  = '{1'b0, 32'hFFFF_F070, 32'h0,         32'h0,         1'b1, 24'h123456};
    vecs[8]  = '{1'b1, 32'hFFFF_F000, 32'h7654_3210, 32'h0,         1'b1, 24'h123456};
    vecs[9]  = '{1'b0, 32'hFFFF_F000, 32'h0,         32'h7654_3210, 1'b1, 24'h123456};
    vecs[10] = '{1'b0, 32'hFFFE_F060, 32'h0,         32'h0,         1'b0, 24'h123456};
    vecs[11] = '{1'b1, 32'hFFFF_F160, 32'h00AA_AAAA, 32'h0,         1'b1, 24'h123456};

    rst = 1'b1; Bus_addr = 32'h0; Bus_we = 1'b0; Bus_wdata = 32'h0; sw = 24'h0;
    repeat (3) tick();
    chk("rst_led", {8'h0, led}, 32'h0);
    chk("rst_dig_en", {24'h0, dig_en}, 32'hFE);
    chk("rst_seg", {24'h0, seg}, 32'hC0);
    chk("rst_hit", {31'h0, periph_hit}, 32'h0);
    Bus_addr = 32'hFFFF_F020; #1;
    chk("rst_timer_rd", Bus_rdata, 32'h0);
    Bus_addr = 32'h0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      Bus_we = vecs[i].we; Bus_addr = vecs[i].addr; Bus_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rdata", i), Bus_rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_hit", i), {31'h0, periph_hit}, {31'h0, vecs[i].exp_hit});
      tick();
      Bus_we = 1'b0;
      chk($sformatf("vec%0d_led", i), {8'h0, led}, {8'h0, vecs[i].exp_led});
    end

    // Align to the 7 -> 0 digit wrap, then sample once per digit period.
    found = 1'b0;
    prev  = dig_en;
    for (int n = 0; n < 64 && !found; n++) begin
      tick();
      if (dig_en == 8'hFE && prev == 8'h7F) found = 1'b1;
      prev = dig_en;
    end
    chk("scan_wrap_seen", {31'h0, found}, 32'h1);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] en_exp;
      en_exp = ~(8'b1 << (k % 8));
      chk($sformatf("scan%0d_dig_en", k), {24'h0, dig_en}, {24'h0, en_exp});
      chk($sformatf("scan%0d_seg", k), {24'h0, seg}, {24'h0, seg_tab[k % 8]});
      repeat (4) tick();
    end

    Bus_addr = 32'hFFFF_F070; sw = 24'h00F00F; #1;
    chk("sw_edge0", Bus_rdata, 32'h0);
    tick();
    chk("sw_edge1", Bus_rdata, 32'h0);
    tick();
    chk("sw_edge2", Bus_rdata, 32'h0000_F00F);
    Bus_we = 1'b1; Bus_wdata = 32'hFFFF_FFFF;
    tick();
    Bus_we = 1'b0;
    chk("sw_write_ignored", Bus_rdata, 32'h0000_F00F);
    chk("sw_write_led", {8'h0, led}, 32'h0012_3456);

`ifdef BUS_TIMER_EN
    Bus_addr = 32'hFFFF_F020; #1;
    tval = Bus_rdata;
    tick();
    Bus_we = 1'b1; Bus_wdata = 32'hFFFF_FFFE; #1;
    chk("timer_old_during_load", Bus_rdata, tval + 32'd1);
    tick();
    Bus_we = 1'b0;
    chk("timer_load", Bus_rdata, 32'hFFFF_FFFE);
    tick();
    chk("timer_inc", Bus_rdata, 32'hFFFF_FFFF);
    tick();
    chk("timer_wrap", Bus_rdata, 32'h0);
`else
    tval = 32'h0;
    Bus_addr = 32'hFFFF_F020; Bus_we = 1'b1; Bus_wdata = 32'h1234 + tval;
    tick();
    Bus_we = 1'b0; #1;
    chk("timer_off_rd0", Bus_rdata, 32'h0);
    tick();
    chk("timer_off_rd1", Bus_rdata, 32'h0);
`endif

    // Reset mid-cycle with a pending LED write: everything clears at once.
    Bus_addr = 32'hFFFF_F060; Bus_we = 1'b1; Bus_wdata = 32'h00FF_FFFF;
    #3 rst = 1'b1;
    #1;
    chk("midrst_led", {8'h0, led}, 32'h0);
    chk("midrst_dig_en", {24'h0, dig_en}, 32'hFE);
    chk("midrst_seg", {24'h0, seg}, 32'hC0);
    tick();
    chk("midrst_led_held", {8'h0, led}, 32'h0);
    Bus_we = 1'b0; Bus_addr = 32'hFFFF_F000; #1;
    chk("midrst_dig_rd", Bus_rdata, 32'h0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
